// File: rtl/sysbus_arb.sv
// Fixed-priority system-bus arbiter (index 0 highest): grant 1 cycle after request, one transaction per grant.
// No backpressure: a grant ends on OK/EN/PE, on request withdrawal, or on timeout, followed by one TURN cycle.
module sysbus_arb #(
   parameter int NREQ = 4,
   parameter int TMO  = 64,
   parameter int IDW  = $clog2(NREQ)
) (
   input  logic            __clk,
   input  logic            clo_n,
   input  logic [NREQ-1:0] zg,
   input  logic            rok,
   input  logic            ren,
   input  logic            rpe,
   output logic [NREQ-1:0] zw,
   output logic            busy,
   output logic [IDW-1:0]  owner,
   output logic            done,
   output logic            done_pe,
   output logic            alarm,
   output logic [IDW-1:0]  alm_id
);

   localparam int TW = $clog2(TMO) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(TMO - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT  = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t          state;
   logic [TW-1:0]   timer;
   logic [IDW-1:0]  win;
   logic [NREQ-1:0] win_oh;

   // Scan from the top so the lowest requesting index is the last write.
   always_comb begin
      win = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (zg[i]) win = IDW'(i);
      end
   end

   assign win_oh = {{(NREQ-1){1'b0}}, 1'b1} << win;
   assign busy   = |zw;

   always_ff @(posedge __clk or negedge clo_n) begin
      if (!clo_n) begin
         state   <= IDLE;
         zw      <= '0;
         owner   <= '0;
         done    <= 1'b0;
         done_pe <= 1'b0;
         alarm   <= 1'b0;
         alm_id  <= '0;
         timer   <= '0;
      end else begin
         done    <= 1'b0;
         done_pe <= 1'b0;
         alarm   <= 1'b0;
         case (state)
            IDLE, TURN: begin
               if (|zg) begin
                  zw    <= win_oh;
                  owner <= win;
                  timer <= '0;
                  state <= GNT;
               end else begin
                  state <= IDLE;
               end
            end
            GNT: begin
               // Withdrawal outranks a response, which outranks the timeout.
               if (!zg[owner]) begin
                  zw    <= '0;
                  state <= TURN;
               end else if (rok | ren | rpe) begin
                  zw      <= '0;
                  done    <= 1'b1;
                  done_pe <= rpe;
                  state   <= TURN;
               end else if (timer == T_LAST) begin
                  zw     <= '0;
                  alarm  <= 1'b1;
                  alm_id <= owner;
                  state  <= TURN;
               end else begin
                  timer <= timer + TW'(1);
               end
            end
            default: begin
               zw    <= '0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
